sync_fifo_flagged: RTL and testbench
====================================

// Module: sync_fifo_flagged
// PURPOSE
//  Parametrised single-clock circular FIFO: next generation of the team's sync FIFO.
//  - Arbitrary depth (not only 2^n), correct wrap and phase bits, single-cycle push/pop.
//  - Occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors.
//  - Sits between a producer and consumer in the same clock domain as the elastic buffer.
// PARAMETERS
//  DATA_WIDTH   64    width of one entry
//  DEPTH        1024  number of entries, >= 2, any integer
//  PTR_W        $clog2(DEPTH)  pointer index width (derived, do not override)
//  AF_LEVEL     DEPTH-2  almost_full_out asserted when count >= AF_LEVEL
//  AE_LEVEL     2     almost_empty_out asserted when count <= AE_LEVEL
// PORTS
//  clk_in            in   1           clock, all logic on rising edge
//  rst_in            in   1           synchronous, active-high reset
//  wr_en_in          in   1           push request
//  data_in           in   DATA_WIDTH  push data
//  rd_en_in          in   1           pop request
//  clr_err_in        in   1           clears sticky error flags
//  data_out          out  DATA_WIDTH  pop data
//  full_out          out  1           no free entry
//  empty_out         out  1           no valid entry
//  almost_full_out   out  1           count >= AF_LEVEL
//  almost_empty_out  out  1           count <= AE_LEVEL
//  count_out         out  PTR_W+1     current occupancy, 0..DEPTH
//  overflow_out      out  1           sticky: push attempted while full
//  underflow_out     out  1           sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset, rst_in=1 at an edge: head=tail=0, both phase bits 0, count=0, data_out=0.
//    empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0.
//    Reset overrides any concurrent push, pop or clear. Memory contents are not reset.
//  - Push accepted iff wr_en_in && !full_out.
//    Accepted push: mem[tail] <= data_in; tail advances.
//  - Pop accepted iff rd_en_in && !empty_out.
//    Accepted pop: data_out <= mem[head], valid the cycle after the pop; head advances.
//  - Pointer advance: idx==DEPTH-1 -> idx=0 and phase bit toggles; otherwise idx+1.
//  - empty when idx equal and phase equal; full when idx equal and phase differs.
//  - Simultaneous accepted push and pop: both pointers move, count unchanged.
//    A simultaneous push does not unblock a pop when empty.
//    A simultaneous pop does not unblock a push when full.
//  - count_out, full_out, empty_out and almost flags are registered.
//    They are computed from next-state count and reflect the new state the cycle after an edge.
//  - Rejected push (wr_en_in && full_out): no state change; overflow_out <= 1.
//  - Rejected pop (rd_en_in && empty_out): no state change, data_out holds; underflow_out <= 1.
//  - clr_err_in=1 clears both sticky flags. A new error in the same cycle wins (flag stays 1).
//  - data_out holds its last value when no pop is accepted.
// CONFIGURATION
//  SYNC_FIFO_FLAGGED_FWFT_EN defined: first-word-fall-through mode.
//    - data_out shows mem[head] whenever !empty_out, and the value is registered.
//    - The first written word appears on data_out 1 cycle after empty_out deasserts.
//    - rd_en_in acknowledges the word and advances head.
//  SYNC_FIFO_FLAGGED_FWFT_EN undefined: standard mode, 1-cycle read latency as described above.
// STRUCTURE
//  Package sync_fifo_pkg:
//    - function ptr_next(idx, phase, depth)
//    - localparam for reset values of pointers and flags
//  Sub-module sync_fifo_ptr: one pointer index plus phase bit, with advance and synchronous reset.
//    Instantiated twice, as head and tail.
//  Top level contains the memory array, the count and flag registers, and the error logic.
// TESTING (DATA_WIDTH=16, DEPTH=6, AF_LEVEL=5, AE_LEVEL=1, standard mode unless noted)
//  - Reset, then 6 pushes 0x0001..0x0006 -> count 6, full=1, almost_full=1 from count 5.
//    A 7th push sets overflow=1 and count stays 6.
//  - From full, 6 pops -> data_out 0x0001..0x0006, each 1 cycle after its pop; then empty=1.
//    A 7th pop sets underflow=1 and data_out holds 0x0006.
//  - 20 pushes and 20 pops interleaved across several wraps of the non-2^n depth.
//    Data must match the scoreboard and the phase bits must toggle at index 5.
//  - Count 3, wr_en and rd_en both high for 4 cycles -> count stays 3 and order is preserved.
//    On an empty FIFO with both high -> only the push is accepted, underflow=1.
//  - overflow=1 while a push is mid-stream, then rst_in=1 for 1 cycle.
//    All outputs return to reset values, and a later push of 0xBEEF pops back as 0xBEEF.
//  - FWFT build: push 0x00AA into the empty FIFO.
//    data_out=0x00AA with rd_en low; a rd_en pulse makes empty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types, reset values and pointer-advance helper for the flagged sync FIFO.
package sync_fifo_pkg;

    typedef struct packed {
        logic        phase;
        logic [31:0] idx;
    } ptr_pair_t;

    localparam logic [31:0] PTR_RST_IDX    = 32'd0;
    localparam logic        PTR_RST_PHASE  = 1'b0;
    localparam logic        FLAG_RST_EMPTY = 1'b1;
    localparam logic        FLAG_RST_FULL  = 1'b0;
    localparam logic        FLAG_RST_AE    = 1'b1;
    localparam logic        FLAG_RST_AF    = 1'b0;
    localparam logic        FLAG_RST_ERR   = 1'b0;

    // Wrap at depth-1 rather than at a power of two; the phase bit flips on each wrap.
    function automatic ptr_pair_t ptr_next(input logic [31:0] idx, input logic phase,
                                           input int unsigned depth);
        ptr_pair_t r;
        if (idx == depth - 1) begin
            r.idx   = 32'd0;
            r.phase = ~phase;
        end else begin
            r.idx   = idx + 32'd1;
            r.phase = phase;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// One FIFO pointer: index plus phase bit with advance and synchronous reset.
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [PTR_W-1:0] idx_o,
    output logic [PTR_W-1:0] idx_nxt_o,
    output logic             phase_nxt_o
);

    logic [PTR_W-1:0] idx_q, idx_d;
    logic             phase_q, phase_d;
    ptr_pair_t        adv;

    always_comb begin
        adv     = ptr_next(32'(idx_q), phase_q, DEPTH);
        idx_d   = idx_q;
        phase_d = phase_q;
        if (adv_i) begin
            idx_d   = PTR_W'(adv.idx);
            phase_d = adv.phase;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= PTR_W'(PTR_RST_IDX);
            phase_q <= PTR_RST_PHASE;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx_o       = idx_q;
    assign idx_nxt_o   = idx_d;
    assign phase_nxt_o = phase_d;

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO of arbitrary depth with registered occupancy/almost flags and sticky errors.
// Define SYNC_FIFO_FLAGGED_FWFT_EN for first-word-fall-through output; default is 1-cycle latency.
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PTR_W      = $clog2(DEPTH),
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en_in,
    input  logic                  clr_err_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  almost_full_out,
    output logic                  almost_empty_out,
    output logic [PTR_W:0]        count_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_idx, head_nxt, tail_idx, tail_nxt;
    logic             head_ph_nxt, tail_ph_nxt;
    logic             push_acc, pop_acc;

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Flags are registered, so acceptance is decided on the pre-edge full/empty state.
    assign push_acc = wr_en_in && !full_q;
    assign pop_acc  = rd_en_in && !empty_q;

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_head (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .adv_i       (pop_acc),
        .idx_o       (head_idx),
        .idx_nxt_o   (head_nxt),
        .phase_nxt_o (head_ph_nxt)
    );

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tail (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .adv_i       (push_acc),
        .idx_o       (tail_idx),
        .idx_nxt_o   (tail_nxt),
        .phase_nxt_o (tail_ph_nxt)
    );

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + 1'b1;
        end else if (!push_acc && pop_acc) begin
            count_d = count_q - 1'b1;
        end
        empty_d = (head_nxt == tail_nxt) && (head_ph_nxt == tail_ph_nxt);
        full_d  = (head_nxt == tail_nxt) && (head_ph_nxt != tail_ph_nxt);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);
    end

    // A fresh error in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = clr_err_in ? 1'b0 : ovf_q;
        udf_d = clr_err_in ? 1'b0 : udf_q;
        if (wr_en_in && full_q) begin
            ovf_d = 1'b1;
        end
        if (rd_en_in && empty_q) begin
            udf_d = 1'b1;
        end
    end

`ifdef SYNC_FIFO_FLAGGED_FWFT_EN
    // Present the post-pop head; skip while the word is being written this same edge.
    always_comb begin
        data_d = data_q;
        if (!empty_q && !empty_d) begin
            data_d = mem_q[head_nxt];
        end
    end
`else
    always_comb begin
        data_d = data_q;
        if (pop_acc) begin
            data_d = mem_q[head_idx];
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (push_acc && !rst_in) begin
            mem_q[tail_idx] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
            full_q  <= FLAG_RST_FULL;
            empty_q <= FLAG_RST_EMPTY;
            af_q    <= FLAG_RST_AF;
            ae_q    <= FLAG_RST_AE;
            ovf_q   <= FLAG_RST_ERR;
            udf_q   <= FLAG_RST_ERR;
            data_q  <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            data_q  <= data_d;
        end
    end

    assign data_out         = data_q;
    assign full_out         = full_q;
    assign empty_out        = empty_q;
    assign almost_full_out  = af_q;
    assign almost_empty_out = ae_q;
    assign count_out        = count_q;
    assign overflow_out     = ovf_q;
    assign underflow_out    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Scoreboard bench for sync_fifo_flagged at DEPTH=6, DATA_WIDTH=16.
module tb_sync_fifo_flagged;

    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, clr;
    logic [DW-1:0] din, dout;
    logic          full, empty, afull, aempty, ovf, udf;
    logic [3:0]    cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [$];
    logic [DW-1:0] exp_q [$];
    int            mcount;
    logic          movf, mudf;
    int            mt_idx, mh_idx;
    logic          mt_ph, mh_ph;
    logic          pop_seen;

    always #5 clk = ~clk;

    sync_fifo_flagged #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .wr_en_in         (wr_en),
        .data_in          (din),
        .rd_en_in         (rd_en),
        .clr_err_in       (clr),
        .data_out         (dout),
        .full_out         (full),
        .empty_out        (empty),
        .almost_full_out  (afull),
        .almost_empty_out (aempty),
        .count_out        (cnt),
        .overflow_out     (ovf),
        .underflow_out    (udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(cnt), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(afull), 32'(mcount >= AF));
        chk("almost_empty", 32'(aempty), 32'(mcount <= AE));
        chk("overflow", 32'(ovf), 32'(movf));
        chk("underflow", 32'(udf), 32'(mudf));
        chk("tail_idx", 32'(dut.u_tail.idx_q), 32'(mt_idx));
        chk("tail_phase", 32'(dut.u_tail.phase_q), 32'(mt_ph));
        chk("head_idx", 32'(dut.u_head.idx_q), 32'(mh_idx));
        chk("head_phase", 32'(dut.u_head.phase_q), 32'(mh_ph));
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c,
                        input logic rs);
        logic push_ok, pop_ok;
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
        rst   = rs;
        @(posedge clk);
        if (rs) begin
            model.delete();
            mcount = 0;
            movf   = 1'b0;
            mudf   = 1'b0;
            mt_idx = 0;
            mh_idx = 0;
            mt_ph  = 1'b0;
            mh_ph  = 1'b0;
        end else begin
            push_ok = w && (mcount < DEPTH);
            pop_ok  = r && (mcount > 0);
            movf    = (c ? 1'b0 : movf) | (w && mcount == DEPTH);
            mudf    = (c ? 1'b0 : mudf) | (r && mcount == 0);
            if (pop_ok) exp_q.push_back(model.pop_front());
            if (push_ok) model.push_back(d);
            mcount = mcount + int'(push_ok) - int'(pop_ok);
            if (push_ok) begin
                if (mt_idx == DEPTH - 1) begin
                    mt_idx = 0;
                    mt_ph  = ~mt_ph;
                end else begin
                    mt_idx++;
                end
            end
            if (pop_ok) begin
                if (mh_idx == DEPTH - 1) begin
                    mh_idx = 0;
                    mh_ph  = ~mh_ph;
                end else begin
                    mh_idx++;
                end
            end
        end
        #1 check_state();
    endtask

`ifndef SYNC_FIFO_FLAGGED_FWFT_EN
    // Pops are checked one cycle after the DUT accepts them.
    initial begin
        forever begin
            @(posedge clk);
            pop_seen = rd_en && !empty && !rst;
            #1;
            if (pop_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_data: got 0x%0h with no pop expected", dout);
                end else begin
                    chk("pop_data", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end
`endif

    initial begin
        int pushes, pops;
        logic w, r;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        din   = '0;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_data", 32'(dout), 32'h0);

`ifdef SYNC_FIFO_FLAGGED_FWFT_EN
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("fwft_first", 32'(dout), 32'h00AA);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("fwft_hold", 32'(dout), 32'h00AA);
        step(1'b1, 16'h00B1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("fwft_second", 32'(dout), 32'h00B1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("fwft_next", 32'(dout), 32'h00B2);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
`else
        // Fill to full, then one rejected push.
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        // Drain, then one rejected pop; data holds the last word.
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("underflow_hold", 32'(dout), 32'h0006);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        // Interleaved traffic wrapping the depth-6 buffer several times.
        pushes = 0;
        pops   = 0;
        for (int i = 0; i < 200 && (pushes < 20 || pops < 20); i++) begin
            w = (pushes < 20) && (mcount < DEPTH) && (i % 4 != 3);
            r = (pops < 20) && (mcount > 0) && (i % 3 != 0);
            step(w, 16'h1000 + 16'(pushes), r, 1'b0, 1'b0);
            if (w) pushes++;
            if (r) pops++;
        end

        // Simultaneous push/pop at count 3, then on an empty FIFO.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h2100 + 16'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h2200, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

        // Overflow mid-stream, then reset with a push still asserted.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3100, 1'b0, 1'b0, 1'b1);
        chk("reset2_data", 32'(dout), 32'h0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("beef_data", 32'(dout), 32'h0000BEEF);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
